// File: rtl/sram_ctrl_if.sv
// Host-facing bus of the SRAM request controller: request, write-data and
// read-response streams plus completion/status flags.
interface sram_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) ();
  // Every stream here follows the same valid/ready rule: a beat transfers on
  // the rising clock edge where valid && ready are both high. The source
  // keeps its payload stable while valid is high and ready is low. Ready may
  // depend on the controller state only, never on valid.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_last;
  logic                  wr_done;
  logic                  busy;

  modport master (
    output req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    input  req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, wr_done, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    output req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, wr_done, busy
  );
endinterface

// File: rtl/sram_ctrl.sv
// Burst request controller in front of a single-port SRAM with a 1-cycle
// registered read. Writes stream at one beat per cycle; reads take three
// cycles per beat (address, data, response) and are held until consumed.
module sram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_ctrl_if.slave            bus,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_last_q;
  logic                  wr_done_q;

  // Ready/busy flags come straight from the state so they never depend on valid.
  assign bus.req_ready   = (state == IDLE);
  assign bus.wdata_ready = (state == WR);
  assign bus.busy        = (state != IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.wr_done     = wr_done_q;

  // The SRAM stores on the same edge the write beat is accepted; a gap writes nothing.
  assign sram_wr_en = (state == WR) && bus.wdata_valid;
  assign sram_addr  = cur_addr;
  assign sram_wdata = bus.wdata;
  assign dbg_state  = state;

  // Burst sequencing: address/count bookkeeping and the registered response stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beat_cnt    <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr <= bus.req_addr;
            beat_cnt <= bus.req_len;
            state    <= bus.req_wr ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (bus.wdata_valid) begin
            cur_addr <= cur_addr + 1'b1;
            if (beat_cnt == '0) begin
              state     <= IDLE;
              wr_done_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          rsp_rdata_q <= sram_rdata;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= (beat_cnt == '0);
          state       <= RD_RESP;
        end
        RD_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              state <= IDLE;
            end else begin
              cur_addr <= cur_addr + 1'b1;
              beat_cnt <= beat_cnt - 1'b1;
              state    <= RD_ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a transaction-level reference model and a
// behavioural SRAM attached to the controller's memory port.
module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic       sram_wr_en;
  logic [7:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;
  logic [2:0] dbg_state;

  sram_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) bus_if ();

  sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural SRAM ----------------
  logic [7:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_wr_en) begin
      sram_mem[sram_addr] <= sram_wdata;
      sram_rdata <= sram_wdata;
    end else begin
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0;
  localparam int M_WR   = 1;
  localparam int M_RD   = 2;

  logic [7:0] m_mem [256];
  logic [8:0] exp_q [$];       // {last, data} per expected read beat
  int         m_mode = M_IDLE;
  logic [7:0] m_addr = '0;
  int         m_left = 0;
  int         m_wait = 0;      // cycles until the current read beat is presented
  bit         m_done_pend = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = '0;
      m_mem[i]    = '0;
    end
    sram_rdata = '0;
  end

  // Per-cycle comparison against the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    bit   e_valid;
    bit   e_wr_en;
    bit   e_done;
    logic [8:0] front;
    if (rst) begin
      m_mode = M_IDLE;
      m_wait = 0;
      m_done_pend = 0;
      exp_q.delete();
      chk("rst_busy", 32'(bus_if.busy), 0);
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
      chk("rst_wr_en", 32'(sram_wr_en), 0);
      chk("rst_wr_done", 32'(bus_if.wr_done), 0);
    end else begin
      if (m_mode == M_RD && m_wait > 0) m_wait--;
      e_valid = (m_mode == M_RD) && (m_wait == 0);
      e_wr_en = (m_mode == M_WR) && bus_if.wdata_valid;
      e_done  = m_done_pend;
      m_done_pend = 0;
      chk("req_ready", 32'(bus_if.req_ready), 32'(m_mode == M_IDLE));
      chk("busy", 32'(bus_if.busy), 32'(m_mode != M_IDLE));
      chk("wdata_ready", 32'(bus_if.wdata_ready), 32'(m_mode == M_WR));
      chk("sram_wr_en", 32'(sram_wr_en), 32'(e_wr_en));
      chk("wr_done", 32'(bus_if.wr_done), 32'(e_done));
      chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(e_valid));
      if (e_wr_en) begin
        chk("wr_addr", 32'(sram_addr), 32'(m_addr));
        chk("wr_data", 32'(sram_wdata), 32'(bus_if.wdata));
      end
      if (m_mode == M_RD && m_wait == 2) chk("rd_addr", 32'(sram_addr), 32'(m_addr));
      if (e_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_queue_empty", 1, 0);
        end else begin
          front = exp_q[0];
          chk("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(front[7:0]));
          chk("rsp_last", 32'(bus_if.rsp_last), 32'(front[8]));
        end
      end
      // model update for the coming edge
      if (m_mode == M_IDLE && bus_if.req_valid) begin
        m_addr = bus_if.req_addr;
        if (bus_if.req_wr) begin
          m_mode = M_WR;
          m_left = int'(bus_if.req_len) + 1;
        end else begin
          m_mode = M_RD;
          m_wait = 3;
          for (int i = 0; i <= int'(bus_if.req_len); i++) begin
            exp_q.push_back({(i == int'(bus_if.req_len)), m_mem[8'(int'(bus_if.req_addr) + i)]});
          end
        end
      end else if (e_wr_en) begin
        m_mem[m_addr] = bus_if.wdata;
        m_addr = m_addr + 8'd1;
        m_left--;
        if (m_left == 0) begin
          m_mode = M_IDLE;
          m_done_pend = 1;
        end
      end else if (e_valid && bus_if.rsp_ready && exp_q.size() > 0) begin
        front = exp_q.pop_front();
        if (front[8]) begin
          m_mode = M_IDLE;
        end else begin
          m_addr = m_addr + 8'd1;
          m_wait = 3;
        end
      end
    end
  end

  // ---------------- monitors for directed literal checks ----------------
  logic [8:0] got_q [$];
  int  first_v  = -1;
  int  acc_cyc  = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  bit  prev_v   = 0;

  // Collect consumed read beats, first-valid cycle, write strobes and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rsp_valid && bus_if.rsp_ready) got_q.push_back({bus_if.rsp_last, bus_if.rsp_rdata});
      if (bus_if.rsp_valid && !prev_v && first_v < 0) first_v = cyc;
      if (sram_wr_en) wr_cnt++;
      if (bus_if.wr_done) done_cnt++;
    end
    prev_v = bus_if.rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
    bit ok = 0;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.req_len   = len;
    bus_if.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.req_ready) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input int gap);
    bit ok = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus_if.wdata       = d;
    bus_if.wdata_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_if.wdata_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wdata_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus_if.wdata_valid = 1'b0;
  endtask

  // Beat i carries dw[8*i +: 8].
  task automatic write_burst(input logic [7:0] addr, input int n, input logic [31:0] dw, input int gap);
    do_req(1'b1, addr, 4'(n - 1));
    for (int i = 0; i < n; i++) send_beat(dw[8*i +: 8], gap);
  endtask

  task automatic wait_beats(input int n);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'(got_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus_if.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input logic [7:0] addr, input int n);
    got_q.delete();
    first_v = -1;
    do_req(1'b0, addr, 4'(n - 1));
    wait_beats(n);
    wait_idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus_if.req_valid   = 1'b0;
    bus_if.req_wr      = 1'b0;
    bus_if.req_addr    = '0;
    bus_if.req_len     = '0;
    bus_if.wdata_valid = 1'b0;
    bus_if.wdata       = '0;
    bus_if.rsp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_req_ready", 32'(bus_if.req_ready), 1);
    chk("reset_busy", 32'(bus_if.busy), 0);
    chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 0);
    chk("reset_rsp_rdata", 32'(bus_if.rsp_rdata), 0);
    chk("reset_sram_addr", 32'(sram_addr), 0);
    @(posedge clk);
    #1;

    // 1: single write then single read with latency
    write_burst(8'h10, 1, 32'h000000A5, 0);
    wait_idle();
    read_burst(8'h10, 1);
    chk("t1_beats", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) chk("t1_data", 32'(got_q[0]), 32'h1A5);
    chk("t1_latency", 32'(first_v - acc_cyc), 3);

    // 2: wrapping write burst and read back
    write_burst(8'hFE, 4, 32'h44332211, 0);
    wait_idle();
    chk("t2_mem_fe", 32'(sram_mem[8'hFE]), 32'h11);
    chk("t2_mem_01", 32'(sram_mem[8'h01]), 32'h44);
    read_burst(8'hFE, 4);
    chk("t2_beats", 32'(got_q.size()), 4);
    if (got_q.size() >= 4) begin
      chk("t2_b0", 32'(got_q[0]), 32'h011);
      chk("t2_b1", 32'(got_q[1]), 32'h022);
      chk("t2_b2", 32'(got_q[2]), 32'h033);
      chk("t2_b3", 32'(got_q[3]), 32'h144);
    end

    // 3: read burst with a stalled second beat
    got_q.delete();
    wr_cnt = 0;
    do_req(1'b0, 8'hFE, 4'd2);
    wait_beats(1);
    bus_if.rsp_ready = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("t3_stalled_valid", 32'(bus_if.rsp_valid), 1);
    chk("t3_stalled_data", 32'(bus_if.rsp_rdata), 32'h22);
    bus_if.rsp_ready = 1'b1;
    wait_beats(3);
    wait_idle();
    chk("t3_beats", 32'(got_q.size()), 3);
    if (got_q.size() >= 3) begin
      chk("t3_b0", 32'(got_q[0]), 32'h011);
      chk("t3_b1", 32'(got_q[1]), 32'h022);
      chk("t3_b2", 32'(got_q[2]), 32'h133);
    end
    chk("t3_no_writes", 32'(wr_cnt), 0);

    // 4: write burst with 2-cycle gaps
    wr_cnt = 0;
    done_cnt = 0;
    write_burst(8'h40, 4, 32'h8D7C6B5A, 2);
    wait_idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t4_writes", 32'(wr_cnt), 4);
    chk("t4_done_pulses", 32'(done_cnt), 1);
    read_burst(8'h40, 4);
    if (got_q.size() >= 4) begin
      chk("t4_b0", 32'(got_q[0]), 32'h05A);
      chk("t4_b3", 32'(got_q[3]), 32'h18D);
    end

    // 5: reset in the middle of a read burst
    got_q.delete();
    bus_if.rsp_ready = 1'b0;
    do_req(1'b0, 8'hFE, 4'd3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) break;
    end
    @(posedge clk);
    #1;
    chk("t5_pre_valid", 32'(bus_if.rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid_drop", 32'(bus_if.rsp_valid), 0);
    chk("t5_busy_drop", 32'(bus_if.busy), 0);
    chk("t5_wr_en_drop", 32'(sram_wr_en), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("t5_req_ready", 32'(bus_if.req_ready), 1);
    @(posedge clk);
    #1;
    read_burst(8'h10, 1);
    if (got_q.size() >= 1) chk("t5_readback", 32'(got_q[0]), 32'h1A5);

    // 6: read request held while a write burst is in progress
    got_q.delete();
    do_req(1'b1, 8'h80, 4'd1);
    fork
      begin
        send_beat(8'hC3, 0);
        send_beat(8'hD4, 1);
      end
      do_req(1'b0, 8'h81, 4'd0);
    join
    wait_beats(1);
    wait_idle();
    if (got_q.size() >= 1) chk("t6_read_new", 32'(got_q[0]), 32'h1D4);
    chk("t6_mem_80", 32'(sram_mem[8'h80]), 32'hC3);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
